// File: rtl/pc_irq_ctrl_pkg.sv
// Shared constants and the sequencer state type for the PC interrupt controller.
package pc_irq_ctrl_pkg;

  localparam int PC_W_DEFAULT = 17;
  localparam logic [PC_W_DEFAULT-1:0] ISR_VEC_DEFAULT = 17'h00010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VECTOR = 2'd1,
    ISR    = 2'd2,
    RETURN = 2'd3
  } state_t;

endpackage

// File: rtl/pc_irq_ctrl_edge_pend.sv
// irq rising-edge detector and pending flag. The flag is cleared only when the
// sequencer accepts the request; an edge in the accepting cycle re-arms it.
module irq_edge_pend (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic accept,
  output logic pending
);

  logic irq_d;
  logic rise;

  assign rise = irq & ~irq_d;

  // Delayed irq for edge detection, and the pending flag itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_d   <= 1'b0;
      pending <= 1'b0;
    end else begin
      irq_d <= irq;
      if (accept) begin
        pending <= rise;
      end else begin
        pending <= pending | rise;
      end
    end
  end

endmodule

// File: rtl/pc_irq_ctrl.sv
// Redirect sequencer between EX branch logic and the PC register: passes
// branches through, enters the ISR (saving EPC, flushing) and returns to EPC.
module pc_irq_ctrl
  import pc_irq_ctrl_pkg::*;
#(
  parameter int              PC_W    = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] ISR_VEC = ISR_VEC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            irq,
  input  logic            ie,
  input  logic            stall_IM_ID,
  input  logic            flow_change_ID_EX,
  input  logic [PC_W-1:0] dst_ID_EX,
  input  logic [PC_W-1:0] pc_ID_EX,
  input  logic            reti_ID_EX,
  output logic            flow_change,
  output logic [PC_W-1:0] dst,
  output logic            flush,
  output logic            int_ack,
  output logic            in_isr,
  output logic [PC_W-1:0] epc
);

  state_t state;
  state_t state_next;
  logic   pending;
  logic   accept;

  // Interrupts are only taken from IDLE, so there is no nesting.
  assign accept = (state == IDLE) & pending & ie & ~stall_IM_ID;

  irq_edge_pend u_edge_pend (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq     (irq),
    .accept  (accept),
    .pending (pending)
  );

  // State register; EPC is the address the interrupted flow would go to next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      epc   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        epc <= flow_change_ID_EX ? dst_ID_EX : pc_ID_EX;
      end
    end
  end

  // Next state and redirect outputs; IDLE and ISR pass the EX branch through.
  always_comb begin
    state_next  = state;
    flow_change = flow_change_ID_EX;
    dst         = dst_ID_EX;
    flush       = flow_change_ID_EX;
    int_ack     = 1'b0;
    in_isr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = VECTOR;
        end
      end
      VECTOR: begin
        flow_change = 1'b1;
        dst         = ISR_VEC;
        flush       = 1'b1;
        int_ack     = 1'b1;
        state_next  = ISR;
      end
      ISR: begin
        in_isr = 1'b1;
        if (reti_ID_EX && !stall_IM_ID) begin
          state_next = RETURN;
        end
      end
      RETURN: begin
        flow_change = 1'b1;
        dst         = epc;
        flush       = 1'b1;
        in_isr      = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/pc_irq_ctrl.md
# pc_irq_ctrl

Interrupt and redirect sequencer for the program counter. Sits between the EX-stage branch logic and the PC register: it passes normal branch/jump redirects through, and overrides them to enter an interrupt service routine (ISR) or return from one. On ISR entry it saves the exception PC (EPC) and flushes the two younger pipeline stages. On return it redirects the PC to EPC.

## Interface
Parameters:
- PC_W, 17, PC / address width
- ISR_VEC, 17'h00010, fixed ISR entry address

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- irq  in  1  external interrupt request; a rising edge sets the pending flag
- ie  in  1  global interrupt enable, from a control register
- stall_IM_ID  in  1  pipeline stall; no redirect is accepted while high
- flow_change_ID_EX  in  1  a branch or jump is taken in EX
- dst_ID_EX  in  PC_W  target of that branch or jump
- pc_ID_EX  in  PC_W  PC+1 of the instruction in EX
- reti_ID_EX  in  1  return-from-interrupt instruction is in EX
- flow_change  out  1  redirect strobe to the PC register
- dst  out  PC_W  redirect target to the PC register
- flush  out  1  kill the IM_ID and ID_EX instructions this cycle
- int_ack  out  1  one-cycle pulse on ISR entry
- in_isr  out  1  high while the ISR executes
- epc  out  PC_W  saved return address

## Operation
- FSM states: IDLE, VECTOR, ISR, RETURN. Reset state is IDLE.
- Pending flag: set on an irq 0→1 edge, using a registered irq_d. Cleared only on acceptance. A new edge while pending is absorbed.
- IDLE:
  - Acceptance condition: pending & ie & !stall_IM_ID.
  - On acceptance: epc <= flow_change_ID_EX ? dst_ID_EX : pc_ID_EX. Clear pending. Go to VECTOR.
  - The same-cycle branch still passes through.
- VECTOR (one cycle): flow_change=1, dst=ISR_VEC, flush=1, int_ack=1. Go to ISR. Any flow_change_ID_EX this cycle is ignored because that instruction is flushed.
- ISR:
  - in_isr=1. Branches pass through.
  - New irq edges set pending but are not accepted; there is no nesting.
  - reti_ID_EX & !stall_IM_ID → RETURN.
  - reti_ID_EX with stall_IM_ID high → wait in ISR.
- RETURN (one cycle): flow_change=1, dst=epc, flush=1, in_isr=1. Go to IDLE. A pending interrupt may be accepted from IDLE one cycle later at the earliest.
- Pass-through, in IDLE and ISR only: flow_change=flow_change_ID_EX, dst=dst_ID_EX, flush=flow_change_ID_EX.
- reti_ID_EX outside ISR is ignored and treated as a no-op.
- Widths: all PC arithmetic is PC_W bits. No wrap handling is needed beyond natural truncation.

## Timing
- Reset values: flow_change=0, dst=0, flush=0, int_ack=0, in_isr=0, epc=0, pending=0, irq_d=0. Reset mid-ISR or mid-VECTOR returns to IDLE and discards pending.
- State, epc, pending and irq_d are registered. Outputs are Moore from state, plus combinational pass-through of flow_change_ID_EX/dst_ID_EX in IDLE and ISR.
- Interrupt latency:
  - irq edge at cycle T → pending high at T+1.
  - Acceptance at T+1 at the earliest, if ie=1 and no stall.
  - VECTOR at T+2, with the PC loading ISR_VEC on the T+2 clock edge.
- A stall during IDLE defers acceptance; pending is held.
- VECTOR and RETURN never coincide with stall_IM_ID high at entry, because acceptance requires no stall.
- ie dropping while pending prevents acceptance; pending stays set until accepted.
- Simultaneous irq edge and acceptance of an older pending request: pending is re-set, and the new request is served after return.

## Structure
- Shared package holds:
  - the state enum (IDLE, VECTOR, ISR, RETURN)
  - the PC_W constant
  - the ISR_VEC default
- Optional sub-module irq_edge_pend, containing the irq_d register, edge detect and pending flag. Everything else stays in one module.

## Test plan
- Basic entry and return:
  - Stimulus: irq pulse in IDLE, pc_ID_EX=17'h00042, no branch, ie=1.
  - Required response: int_ack one cycle, flush=1, dst=17'h00010, epc=17'h00042.
  - Then reti_ID_EX in ISR → dst=17'h00042, flush=1, in_isr falls.
- Branch on acceptance cycle:
  - Stimulus: flow_change_ID_EX=1, dst_ID_EX=17'h00200 with pending set.
  - Required response: the branch passes through, epc=17'h00200, VECTOR follows next cycle.
- Stall deferral: pending with stall_IM_ID high for 3 cycles → no int_ack during the stall; acceptance on the first unstalled cycle.
- Nesting blocked: second irq edge inside the ISR → no int_ack. After reti, the second interrupt enters, with int_ack 2 cycles after RETURN.
- Enable gating: ie=0 with a pending request → stays in IDLE indefinitely. Raising ie → acceptance the next cycle.
- Reset mid-ISR: rst_n low for one cycle while in ISR → all outputs zero. A following reti_ID_EX is ignored.
